// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter
// Description : Two-requester valid/ready arbiter feeding a single registered
//               output slot. Grant is combinational with a rotating priority
//               pointer; the output slot can drain and refill in one cycle.
//               Optional grant-hold (lock) inputs are enabled by defining the
//               macro MUX_ARBITER_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    input  logic              y_ready_i,
    output logic              sel_o
`ifdef MUX_ARBITER_LOCK_EN
    ,
    input  logic              a_lock_i,
    input  logic              b_lock_i
`endif
);

    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic              r_prefer_b;
    logic [DATA_W-1:0] r_data;
    logic              r_sel;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_can_accept;
    logic              w_xfer_a;
    logic              w_xfer_b;
    logic              w_hold_a;
    logic              w_hold_b;

`ifdef MUX_ARBITER_LOCK_EN
    // A locked winner keeps the priority pointer on itself
    assign w_hold_a = a_lock_i;
    assign w_hold_b = b_lock_i;
`else
    assign w_hold_a = 1'b0;
    assign w_hold_b = 1'b0;
`endif

    // Combinational grant: sole requester wins, ties broken by the pointer
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (a_valid_i && b_valid_i) begin
            w_grant_a = !r_prefer_b;
            w_grant_b = r_prefer_b;
        end else begin
            w_grant_a = a_valid_i;
            w_grant_b = b_valid_i;
        end
    end

    // Slot can take a word when empty or when its current word leaves now
    assign w_can_accept = (r_state == c_st_empty) || y_ready_i;
    // Readies are held low during reset so nothing is accepted on that edge
    assign a_ready_o    = w_grant_a && w_can_accept && reset_n;
    assign b_ready_o    = w_grant_b && w_can_accept && reset_n;
    assign w_xfer_a     = a_valid_i && a_ready_o;
    assign w_xfer_b     = b_valid_i && b_ready_o;

    // State register for the output slot
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: any accepted word fills the slot, a bare drain empties it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_empty: begin
                if (w_xfer_a || w_xfer_b) w_state_next = c_st_full;
            end
            c_st_full: begin
                if (w_xfer_a || w_xfer_b) w_state_next = c_st_full;
                else if (y_ready_i)      w_state_next = c_st_empty;
            end
            default: w_state_next = c_st_empty;
        endcase
    end

    // Output decode from state
    always_comb begin
        y_valid_o = (r_state == c_st_full);
    end

    // Datapath and priority pointer; data/sel retain their value on drain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_sel      <= 1'b0;
            r_prefer_b <= 1'b0;
        end else if (w_xfer_a) begin
            r_data     <= a_data_i;
            r_sel      <= 1'b0;
            r_prefer_b <= !w_hold_a;
        end else if (w_xfer_b) begin
            r_data     <= b_data_i;
            r_sel      <= 1'b1;
            r_prefer_b <= w_hold_b;
        end
    end

    assign y_data_o = r_data;
    assign sel_o    = r_sel;

endmodule
`default_nettype wire
